// File: rtl/z80_ex_ind_sp_ixiy_exec.sv
// EX (SP),IX / EX (SP),IY sequencer: read SP, read SP+1, write SP+1, write SP on a byte bus.
// Optional z80fi retirement trace ports are built when Z80FI_TRACE_EN is defined.
module z80_ex_ind_sp_ixiy_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        iy,
  input  logic [15:0] sp_in,
  input  logic [15:0] ix_in,
  input  logic [15:0] iy_in,
  input  logic [15:0] ip_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] ix_out,
  output logic [15:0] iy_out,
  output logic [15:0] ip_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
`ifdef Z80FI_TRACE_EN
  output logic        z80fi_valid,
  output logic [15:0] z80fi_insn,
  output logic [3:0]  z80fi_insn_len,
  output logic [15:0] z80fi_mem_raddr,
  output logic [15:0] z80fi_mem_raddr2,
  output logic [15:0] z80fi_mem_waddr,
  output logic [15:0] z80fi_mem_waddr2,
  output logic [7:0]  z80fi_mem_rdata,
  output logic [7:0]  z80fi_mem_rdata2,
  output logic [7:0]  z80fi_mem_wdata,
  output logic [7:0]  z80fi_mem_wdata2,
`endif
  input  logic        mem_ack
);

  typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StWrHi, StWrLo, StDone} state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] ix_out_q, ix_out_d;
  logic [15:0] iy_out_q, iy_out_d;
  logic [15:0] ip_out_q, ip_out_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  // Operands latched on start
  logic        sel_iy_q, sel_iy_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] ix_q, ix_d;
  logic [15:0] iy_q, iy_d;
  logic [15:0] ip_q, ip_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;

`ifdef Z80FI_TRACE_EN
  logic        fi_valid_q, fi_valid_d;
  logic [15:0] fi_insn_q, fi_insn_d;
  logic [3:0]  fi_len_q, fi_len_d;
  logic [15:0] fi_raddr_q, fi_raddr_d;
  logic [15:0] fi_raddr2_q, fi_raddr2_d;
  logic [15:0] fi_waddr_q, fi_waddr_d;
  logic [15:0] fi_waddr2_q, fi_waddr2_d;
  logic [7:0]  fi_rdata_q, fi_rdata_d;
  logic [7:0]  fi_rdata2_q, fi_rdata2_d;
  logic [7:0]  fi_wdata_q, fi_wdata_d;
  logic [7:0]  fi_wdata2_q, fi_wdata2_d;
`endif

  logic        ack_ok;
  logic [15:0] sp_p1;
  logic [15:0] sel_reg;

  assign ack_ok  = mem_ack & mem_req_q;
  assign sp_p1   = sp_q + 16'd1;
  assign sel_reg = sel_iy_q ? iy_q : ix_q;

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    ix_out_d    = ix_out_q;
    iy_out_d    = iy_out_q;
    ip_out_d    = ip_out_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sel_iy_d    = sel_iy_q;
    sp_d        = sp_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    ip_d        = ip_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
`ifdef Z80FI_TRACE_EN
    fi_valid_d  = 1'b0;
    fi_insn_d   = fi_insn_q;
    fi_len_d    = fi_len_q;
    fi_raddr_d  = fi_raddr_q;
    fi_raddr2_d = fi_raddr2_q;
    fi_waddr_d  = fi_waddr_q;
    fi_waddr2_d = fi_waddr2_q;
    fi_rdata_d  = fi_rdata_q;
    fi_rdata2_d = fi_rdata2_q;
    fi_wdata_d  = fi_wdata_q;
    fi_wdata2_d = fi_wdata2_q;
`endif

    // Bus outputs are computed for the state being entered so they are registered on entry.
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRdLo;
          sel_iy_d   = iy;
          sp_d       = sp_in;
          ix_d       = ix_in;
          iy_d       = iy_in;
          ip_d       = ip_in;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = sp_in;
        end
      end
      StRdLo: begin
        if (ack_ok) begin
          state_d    = StRdHi;
          lo_d       = mem_rdata;
          mem_addr_d = sp_p1;
        end
      end
      StRdHi: begin
        if (ack_ok) begin
          state_d     = StWrHi;
          hi_d        = mem_rdata;
          mem_we_d    = 1'b1;
          mem_addr_d  = sp_p1;
          mem_wdata_d = sel_reg[15:8];
        end
      end
      StWrHi: begin
        if (ack_ok) begin
          state_d     = StWrLo;
          mem_addr_d  = sp_q;
          mem_wdata_d = sel_reg[7:0];
        end
      end
      StWrLo: begin
        if (ack_ok) begin
          state_d   = StDone;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ix_out_d  = sel_iy_q ? ix_q : {hi_q, lo_q};
          iy_out_d  = sel_iy_q ? {hi_q, lo_q} : iy_q;
          ip_out_d  = ip_q + 16'd2;
`ifdef Z80FI_TRACE_EN
          fi_valid_d  = 1'b1;
          fi_insn_d   = sel_iy_q ? 16'hFDE3 : 16'hDDE3;
          fi_len_d    = 4'd2;
          fi_raddr_d  = sp_q;
          fi_raddr2_d = sp_p1;
          fi_rdata_d  = lo_q;
          fi_rdata2_d = hi_q;
          fi_waddr_d  = sp_q;
          fi_waddr2_d = sp_p1;
          fi_wdata_d  = sel_reg[7:0];
          fi_wdata2_d = sel_reg[15:8];
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ix_out_q    <= 16'h0000;
      iy_out_q    <= 16'h0000;
      ip_out_q    <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      sel_iy_q    <= 1'b0;
      sp_q        <= 16'h0000;
      ix_q        <= 16'h0000;
      iy_q        <= 16'h0000;
      ip_q        <= 16'h0000;
      lo_q        <= 8'h00;
      hi_q        <= 8'h00;
`ifdef Z80FI_TRACE_EN
      fi_valid_q  <= 1'b0;
      fi_insn_q   <= 16'h0000;
      fi_len_q    <= 4'd0;
      fi_raddr_q  <= 16'h0000;
      fi_raddr2_q <= 16'h0000;
      fi_waddr_q  <= 16'h0000;
      fi_waddr2_q <= 16'h0000;
      fi_rdata_q  <= 8'h00;
      fi_rdata2_q <= 8'h00;
      fi_wdata_q  <= 8'h00;
      fi_wdata2_q <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ix_out_q    <= ix_out_d;
      iy_out_q    <= iy_out_d;
      ip_out_q    <= ip_out_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sel_iy_q    <= sel_iy_d;
      sp_q        <= sp_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      ip_q        <= ip_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
`ifdef Z80FI_TRACE_EN
      fi_valid_q  <= fi_valid_d;
      fi_insn_q   <= fi_insn_d;
      fi_len_q    <= fi_len_d;
      fi_raddr_q  <= fi_raddr_d;
      fi_raddr2_q <= fi_raddr2_d;
      fi_waddr_q  <= fi_waddr_d;
      fi_waddr2_q <= fi_waddr2_d;
      fi_rdata_q  <= fi_rdata_d;
      fi_rdata2_q <= fi_rdata2_d;
      fi_wdata_q  <= fi_wdata_d;
      fi_wdata2_q <= fi_wdata2_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ix_out    = ix_out_q;
  assign iy_out    = iy_out_q;
  assign ip_out    = ip_out_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef Z80FI_TRACE_EN
  assign z80fi_valid      = fi_valid_q;
  assign z80fi_insn       = fi_insn_q;
  assign z80fi_insn_len   = fi_len_q;
  assign z80fi_mem_raddr  = fi_raddr_q;
  assign z80fi_mem_raddr2 = fi_raddr2_q;
  assign z80fi_mem_waddr  = fi_waddr_q;
  assign z80fi_mem_waddr2 = fi_waddr2_q;
  assign z80fi_mem_rdata  = fi_rdata_q;
  assign z80fi_mem_rdata2 = fi_rdata2_q;
  assign z80fi_mem_wdata  = fi_wdata_q;
  assign z80fi_mem_wdata2 = fi_wdata2_q;
`endif

endmodule
